// File: rtl/display_arbiter_pkg.sv
// Shared display constants and arbiter state encoding for the display arbiter slice.
package display_arbiter_pkg;

    localparam int DISP_DIGITS   = 8;
    localparam int DISP_NIBBLE_W = 4;
    localparam int DISP_DATA_W   = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

endpackage

// File: rtl/display_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after the last granted index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        k       = 0;
        // Scan from last+1 and wrap so the last winner is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(i_last) + i) % NUM_REQ;
            if (!o_any && i_req[k]) begin
                o_any      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares one seven-segment driver between NUM_REQ requesters with round-robin grants,
// a minimum hold time per grant, and an idle source shown when nobody is granted.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2500000,
    parameter int CNT_W       = 22,
    parameter int OWN_W       = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_reqValid,
    output logic [NUM_REQ-1:0]             o_reqReady,
    input  logic [NUM_REQ*DISP_DATA_W-1:0] i_reqData,
    input  logic [NUM_REQ*DISP_DIGITS-1:0] i_reqEnable,
    input  logic [NUM_REQ*DISP_DIGITS-1:0] i_reqDots,
    input  logic [DISP_DATA_W-1:0]         i_idleData,
    input  logic [DISP_DIGITS-1:0]         i_idleEnable,
    input  logic [DISP_DIGITS-1:0]         i_idleDots,
    output logic [DISP_DATA_W-1:0]         o_data,
    output logic [DISP_DIGITS-1:0]         o_enableDigit,
    output logic [DISP_DIGITS-1:0]         o_dots,
    output logic [OWN_W-1:0]               o_owner,
    output logic                           o_busy
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OWN_W-1:0]       ptr_q, ptr_d;
    logic [DISP_DATA_W-1:0] data_q, data_d;
    logic [DISP_DIGITS-1:0] en_q, en_d;
    logic [DISP_DIGITS-1:0] dots_q, dots_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     win_grant;
    logic [OWN_W-1:0]       win_idx;
    logic                   win_any;
    logic                   slot_open;
    logic                   xfer;
    logic [DISP_DATA_W-1:0] win_data;
    logic [DISP_DIGITS-1:0] win_en;
    logic [DISP_DIGITS-1:0] win_dots;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr (
        .i_req   (i_reqValid),
        .i_last  (ptr_q),
        .o_grant (win_grant),
        .o_idx   (win_idx),
        .o_any   (win_any)
    );

    // Handshake: o_reqReady is the winner's one-hot bit during an open grant slot; a transfer
    // happens on the edge where valid and ready are both high. Reset forces ready low.
    assign slot_open  = (state_q == ST_IDLE) || (cnt_q == '0);
    assign xfer       = slot_open && win_any && !i_reset;
    assign o_reqReady = xfer ? win_grant : '0;

    always_comb begin
        win_data = '0;
        win_en   = '0;
        win_dots = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == OWN_W'(k)) begin
                win_data = i_reqData[k*DISP_DATA_W +: DISP_DATA_W];
                win_en   = i_reqEnable[k*DISP_DIGITS +: DISP_DIGITS];
                win_dots = i_reqDots[k*DISP_DIGITS +: DISP_DIGITS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        en_d    = en_q;
        dots_d  = dots_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        if (xfer) begin
            state_d = ST_SHOW;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            ptr_d   = win_idx;
            data_d  = win_data;
            en_d    = win_en;
            dots_d  = win_dots;
            owner_d = win_idx;
            busy_d  = 1'b1;
        end else if (state_q == ST_SHOW && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            // Idle, or hold expired with nobody waiting: track the idle source.
            state_d = ST_IDLE;
            data_d  = i_idleData;
            en_d    = i_idleEnable;
            dots_d  = i_idleDots;
            owner_d = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= OWN_W'(NUM_REQ - 1);
            data_q  <= '0;
            en_q    <= '0;
            dots_q  <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            dots_q  <= dots_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign o_data        = data_q;
    assign o_enableDigit = en_q;
    assign o_dots        = dots_q;
    assign o_owner       = owner_q;
    assign o_busy        = busy_q;

endmodule
